// File: rtl/i2c_ctrl_if.sv
// Open-drain I2C pin pair. Each side can only pull a line low; the resolved
// level is high (external pull-up) unless someone pulls.
interface i2c_if;
  logic sda_pull;
  logic scl_pull;
  logic sda_tgt_pull;
  logic sda;
  logic scl;

  assign sda = !(sda_pull || sda_tgt_pull);
  assign scl = !scl_pull;

  modport ctrl (output sda_pull, output scl_pull, input sda);
  modport tgt  (output sda_tgt_pull, input sda, input scl);
endinterface

// File: rtl/i2c_ctrl.sv
// Single-master I2C controller: host feed/busy/idle handshake to START,
// address/data bytes with ACK slots and STOP on an open-drain bus.
module i2c_ctrl #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       rstn,
  i2c_if.ctrl        i2c,
  input  logic       feed,
  input  logic [7:0] addr,
  inout  wire  [7:0] data,
  input  logic       rx_ack,
  output logic       tx_ack,
  output logic       busy,
  output logic       idle
);

  localparam int unsigned CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] T_MID  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] T_HIGH = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] T_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] T_STOP = CW'(CLK_DIV / 2 + CLK_DIV - 1);

  typedef enum logic [2:0] {
    BUS_FREE,
    READY,
    START,
    WINDOW,
    BYTE,
    STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic          first_q;
  logic          rw_q;
  logic          byte_rx_q;
  logic          ack_q;
  logic [7:0]    tx_sh_q;
  logic [7:0]    rx_sh_q;
  logic [7:0]    rx_q;
  logic          sda_pull_q;
  logic          scl_pull_q;
  logic          busy_q;
  logic          idle_q;
  logic          tx_ack_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BUS_FREE;
      cnt_q      <= '0;
      bit_q      <= '0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      byte_rx_q  <= 1'b0;
      ack_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_q       <= '0;
      sda_pull_q <= 1'b0;
      scl_pull_q <= 1'b0;
      busy_q     <= 1'b0;
      idle_q     <= 1'b1;
      tx_ack_q   <= 1'b1;
    end else begin
      case (state_q)
        BUS_FREE: begin
          if (cnt_q == T_END) begin
            state_q <= READY;
            idle_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        READY: begin
          if (!feed) begin
            state_q    <= START;
            busy_q     <= 1'b1;
            sda_pull_q <= 1'b1;
            first_q    <= 1'b1;
            cnt_q      <= '0;
          end
        end

        START: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == T_HIGH) scl_pull_q <= 1'b1;
          if (cnt_q == T_END) begin
            state_q <= WINDOW;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end

        WINDOW: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == T_END) begin
            cnt_q <= '0;
            if (feed) begin
              state_q    <= STOP;
              idle_q     <= 1'b1;
              sda_pull_q <= 1'b1;
            end else begin
              state_q <= BYTE;
              busy_q  <= 1'b1;
              bit_q   <= '0;
              first_q <= 1'b0;
              if (first_q) begin
                tx_sh_q   <= addr;
                rw_q      <= addr[0];
                byte_rx_q <= 1'b0;
              end else if (!rw_q) begin
                tx_sh_q   <= data;
                byte_rx_q <= 1'b0;
              end else begin
                sda_pull_q <= 1'b0;
                byte_rx_q  <= 1'b1;
              end
            end
          end
        end

        BYTE: begin
          cnt_q <= cnt_q + CW'(1);
          if (bit_q == 4'd8 && cnt_q == '0) ack_q <= rx_ack;
          // SDA moves at the SCL-low midpoint; the ACK slot is bit index 8.
          if (cnt_q == T_MID) begin
            if (bit_q == 4'd8) begin
              sda_pull_q <= byte_rx_q ? ack_q : 1'b0;
            end else if (byte_rx_q) begin
              sda_pull_q <= 1'b0;
            end else begin
              sda_pull_q <= !tx_sh_q[7];
              tx_sh_q    <= {tx_sh_q[6:0], 1'b0};
            end
          end
          if (cnt_q == T_HIGH) begin
            scl_pull_q <= 1'b0;
            if (bit_q == 4'd8) begin
              if (!byte_rx_q) tx_ack_q <= i2c.sda;
            end else if (byte_rx_q) begin
              rx_sh_q <= {rx_sh_q[6:0], i2c.sda};
              if (bit_q == 4'd7) rx_q <= {rx_sh_q[6:0], i2c.sda};
            end
          end
          if (cnt_q == T_END) begin
            scl_pull_q <= 1'b1;
            cnt_q      <= '0;
            if (bit_q == 4'd8) begin
              state_q <= WINDOW;
              busy_q  <= 1'b0;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end

        STOP: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == T_MID) scl_pull_q <= 1'b0;
          if (cnt_q == T_STOP) begin
            sda_pull_q <= 1'b0;
            state_q    <= BUS_FREE;
            cnt_q      <= '0;
          end
        end

        default: state_q <= BUS_FREE;
      endcase
    end
  end

  assign i2c.sda_pull = sda_pull_q;
  assign i2c.scl_pull = scl_pull_q;
  assign tx_ack       = tx_ack_q;
  assign busy         = busy_q;
  assign idle         = idle_q;
  assign data         = addr[0] ? rx_q : 'z;

endmodule

// File: tb/tb_i2c_ctrl.sv
// Bench for i2c_ctrl: behavioural bus target plus a scoreboard of expected
// START / byte+ACK / STOP events.
module tb_i2c_ctrl;
  localparam int unsigned CLK_DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       feed;
  logic       rx_ack;
  logic [7:0] addr;
  logic [7:0] tb_data;
  wire  [7:0] data;
  logic       tx_ack;
  logic       busy;
  logic       idle;

  i2c_if bus ();

  assign data = addr[0] ? 8'bz : tb_data;

  i2c_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .i2c   (bus),
    .feed  (feed),
    .addr  (addr),
    .data  (data),
    .rx_ack(rx_ack),
    .tx_ack(tx_ack),
    .busy  (busy),
    .idle  (idle)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Event encoding: {kind, byte, ack}; kind 0=START 1=BYTE 2=STOP
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  pay[4];
  logic        mon_en;
  logic        tgt_present;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and target model share one process so they see a consistent bus.
  logic        m_scl, m_sda;
  logic        t_first, t_sel, t_rd, t_send;
  logic [8:0]  fr;
  logic [7:0]  txb;
  int unsigned nbit;

  always @(negedge clk) begin
    if (!mon_en) begin
      bus.sda_tgt_pull = 1'b0;
      nbit    = 0;
      t_first = 1'b0;
      t_sel   = 1'b0;
      t_rd    = 1'b0;
      t_send  = 1'b0;
      m_scl   = bus.scl;
      m_sda   = bus.sda;
    end else begin
      if (m_scl && bus.scl && m_sda && !bus.sda) begin
        obs_q.push_back({2'd0, 8'h00, 1'b0});
        nbit = 0; t_first = 1'b1; t_sel = 1'b0; t_send = 1'b0;
      end else if (m_scl && bus.scl && !m_sda && bus.sda) begin
        obs_q.push_back({2'd2, 8'h00, 1'b0});
        t_first = 1'b0; t_sel = 1'b0; t_send = 1'b0;
      end else if (!m_scl && bus.scl) begin
        fr = {fr[7:0], bus.sda};
        nbit++;
        if (nbit == 9) obs_q.push_back({2'd1, fr[8:1], fr[0]});
      end else if (m_scl && !bus.scl) begin
        if (nbit == 8) begin
          if (t_first) begin
            t_sel = tgt_present && (fr[7:1] == 7'h50 || fr[7:1] == 7'h19);
            t_rd  = fr[0];
          end
          if (t_send) bus.sda_tgt_pull = 1'b0;
          else if (t_sel) bus.sda_tgt_pull = 1'b1;
        end else if (nbit == 9) begin
          bus.sda_tgt_pull = 1'b0;
          nbit   = 0;
          t_send = t_sel && t_rd && (t_first || fr[0] == 1'b0) && rd_q.size() > 0;
          t_first = 1'b0;
          if (t_send) begin
            txb = rd_q.pop_front();
            bus.sda_tgt_pull = !txb[7];
          end
        end else if (nbit >= 1 && nbit <= 7 && t_send) begin
          bus.sda_tgt_pull = !txb[7 - nbit];
        end
      end
      m_scl = bus.scl;
      m_sda = bus.sda;
    end
  end

  task automatic drain();
    logic [10:0] o;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(o), 32'h7ff);
      else chk("sb_event", 32'(o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int unsigned k = 0;
    while (busy !== v && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (busy !== v) chk(tag, busy, v);
  endtask

  task automatic wait_idle(input logic v, input string tag);
    int unsigned k = 0;
    while (idle !== v && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (idle !== v) chk(tag, idle, v);
  endtask

  task automatic xfer(input logic [7:0] a, input int unsigned n, input logic aack);
    addr = a;
    exp_q.push_back({2'd0, 8'h00, 1'b0});
    exp_q.push_back({2'd1, a, aack});
    if (a[0]) for (int unsigned i = 0; i < n; i++) rd_q.push_back(pay[i]);
    feed = 1'b0;
    wait_busy(1'b1, "start_busy_timeout");
    wait_busy(1'b0, "start_win_timeout");
    wait_busy(1'b1, "addr_busy_timeout");
    wait_busy(1'b0, "addr_win_timeout");
    drain();
    chk("tx_ack_addr", tx_ack, aack);
    for (int unsigned i = 0; i < n; i++) begin
      if (!a[0]) tb_data = pay[i];
      exp_q.push_back({2'd1, pay[i], !rx_ack});
      wait_busy(1'b1, "byte_busy_timeout");
      wait_busy(1'b0, "byte_win_timeout");
      drain();
      if (a[0]) chk("rx_data", data, pay[i]);
      else      chk("tx_ack_data", tx_ack, 1'b0);
    end
    feed = 1'b1;
    exp_q.push_back({2'd2, 8'h00, 1'b0});
    wait_idle(1'b1, "stop_idle_timeout");
    chk("stop_busy", busy, 1'b0);
    wait_idle(1'b0, "ready_timeout");
    drain();
    chk("sb_left", exp_q.size(), 0);
    chk("ready_sda_rel", bus.sda, 1'b1);
    chk("ready_scl_rel", bus.scl, 1'b1);
  endtask

  initial begin
    int unsigned n;
    rstn = 1'b0; feed = 1'b1; addr = 8'h00; tb_data = 8'h00;
    rx_ack = 1'b1; mon_en = 1'b0; tgt_present = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sda_pull", bus.sda_pull, 1'b0);
    chk("rst_scl_pull", bus.scl_pull, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_tx_ack", tx_ack, 1'b1);

    mon_en = 1'b1;
    rstn   = 1'b1;
    n = 0;
    while (idle === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bus_free_len", n, 2 * CLK_DIV);
    repeat (10) @(negedge clk);
    chk("ready_idle", idle, 1'b0);
    chk("ready_sda", bus.sda_pull, 1'b0);
    chk("ready_scl", bus.scl_pull, 1'b0);
    chk("ready_quiet", obs_q.size(), 0);

    pay[0] = 8'h55;
    xfer(8'hA0, 1, 1'b0);

    pay[0] = 8'h05; pay[1] = 8'h12; pay[2] = 8'hD7;
    xfer(8'h32, 3, 1'b0);

    pay[0] = 8'hAB; pay[1] = 8'hCC;
    xfer(8'h33, 2, 1'b0);

    tgt_present = 1'b0;
    xfer(8'hA0, 0, 1'b1);
    tgt_present = 1'b1;

    addr = 8'hA0; tb_data = 8'h99; feed = 1'b0;
    wait_busy(1'b1, "mid_start_timeout");
    wait_busy(1'b0, "mid_win_timeout");
    wait_busy(1'b1, "mid_byte_timeout");
    repeat (35) @(negedge clk);
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    chk("midrst_sda_pull", bus.sda_pull, 1'b0);
    chk("midrst_scl_pull", bus.scl_pull, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_idle", idle, 1'b1);
    exp_q.delete();
    obs_q.delete();
    rd_q.delete();
    feed = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    wait_idle(1'b0, "post_rst_ready_timeout");
    mon_en = 1'b1;
    @(negedge clk);

    pay[0] = 8'h3C;
    xfer(8'hA0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
